// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: matrix address map (kept as defines so the
// matrix decode uses the same field positions), FSM encoding and small helpers.
`ifndef WEIGHT_LOADER_DEFINES
`define WEIGHT_LOADER_DEFINES
`define WEIGHT_ADDR_MASK 8'hA5
`define WADDR_D_LSB 13
`define WADDR_S_LSB 2
`define WADDR_IDX_W 11
`endif

package weight_loader_pkg;

  localparam logic [7:0]  WeightAddrMask = `WEIGHT_ADDR_MASK;
  localparam int unsigned AddrIdxW       = `WADDR_IDX_W;

  typedef enum logic [1:0] {StIdle, StWrite, StRdWait, StCheck} wl_state_e;

  function automatic logic [31:0] make_addr(input logic [AddrIdxW-1:0] s,
                                            input logic [AddrIdxW-1:0] d);
    logic [31:0] a;
    a = {WeightAddrMask, 24'h000000};
    a[`WADDR_D_LSB +: AddrIdxW] = d;
    a[`WADDR_S_LSB +: AddrIdxW] = s;
    return a;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Loads coupling weights into the coupled-cell matrix one entry at a time, optionally
// reading each back and counting mismatches.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned NUM_WEIGHTS = 5,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned VERIFY      = 1
) (
  input  logic                           clk,
  input  logic                           axi_rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(N)-1:0]           in_s,
  input  logic [$clog2(N)-1:0]           in_d,
  input  logic [$clog2(NUM_WEIGHTS)-1:0] in_weight,
  output logic                           wready,
  output logic [31:0]                    wr_addr,
  output logic [31:0]                    wdata,
  output logic [31:0]                    rd_addr,
  input  logic [31:0]                    rdata,
  output logic                           busy,
  output logic [15:0]                    wr_count,
  output logic [15:0]                    err_count,
  output logic [31:0]                    err_addr,
  output logic                           bad_idx
);

  localparam int unsigned WEIGHT_W = $clog2(NUM_WEIGHTS);
  localparam logic [3:0]  LatLoad  = 4'(READ_LAT - 1);

  wl_state_e   state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        wready_q, wready_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        bad_idx_q, bad_idx_d;
  logic        unused_rdata;

  assign unused_rdata = ^rdata[31:WEIGHT_W];

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    bad_idx_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_s == in_d) begin
            bad_idx_d = 1'b1;
          end else begin
            addr_d  = make_addr(AddrIdxW'(in_s), AddrIdxW'(in_d));
            wdata_d = 32'(in_weight);
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        wr_count_d = sat_inc(wr_count_q);
        lat_cnt_d  = LatLoad;
        state_d    = (VERIFY != 0) ? StRdWait : StIdle;
      end
      StRdWait: begin
        if (lat_cnt_q == 4'd0) state_d = StCheck;
        else                   lat_cnt_d = lat_cnt_q - 4'd1;
      end
      StCheck: begin
        if (rdata[WEIGHT_W-1:0] != wdata_q[WEIGHT_W-1:0]) begin
          err_count_d = sat_inc(err_count_q);
          err_addr_d  = addr_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Handshake/status outputs are registered from the next state so they align with it.
    wready_d   = (state_d == StWrite);
    in_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q     <= StIdle;
      lat_cnt_q   <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wr_count_q  <= 16'd0;
      err_count_q <= 16'd0;
      err_addr_q  <= 32'd0;
      wready_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      bad_idx_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      wready_q    <= wready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      bad_idx_q   <= bad_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wready    = wready_q;
  assign wr_addr   = addr_q;
  assign rd_addr   = addr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign bad_idx   = bad_idx_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: one verifying instance (READ_LAT=2) driven with directed and
// random entries against a transaction-level model, plus a non-verifying instance.
module tb_weight_loader;
  import weight_loader_pkg::*;

  localparam int unsigned RL = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned WW = 3;
  localparam logic [7:0]  MASK = WeightAddrMask;

  logic clk = 1'b0;
  logic axi_rst;
  always #5 clk = ~clk;

  logic          valid_v, in_ready_v, wready_v, busy_v, bad_idx_v;
  logic [IW-1:0] in_s_v, in_d_v;
  logic [WW-1:0] in_w_v;
  logic [31:0]   wr_addr_v, wdata_v, rd_addr_v, rdata_v, err_addr_v;
  logic [15:0]   wr_count_v, err_count_v;
  logic          mis_en;
  logic [31:0]   mis_val;

  logic          valid_nv, in_ready_nv, wready_nv, busy_nv, bad_idx_nv;
  logic [IW-1:0] in_s_nv, in_d_nv;
  logic [WW-1:0] in_w_nv;
  logic [31:0]   wr_addr_nv, wdata_nv, rd_addr_nv, err_addr_nv;
  logic [15:0]   wr_count_nv, err_count_nv;

  // Matrix stand-in: readback returns what was written unless a mismatch is forced.
  assign rdata_v = mis_en ? mis_val : wdata_v;

  weight_loader #(.N(8), .NUM_WEIGHTS(5), .READ_LAT(RL), .VERIFY(1)) u_dut_v (
    .clk(clk), .axi_rst(axi_rst), .in_valid(valid_v), .in_ready(in_ready_v),
    .in_s(in_s_v), .in_d(in_d_v), .in_weight(in_w_v), .wready(wready_v),
    .wr_addr(wr_addr_v), .wdata(wdata_v), .rd_addr(rd_addr_v), .rdata(rdata_v),
    .busy(busy_v), .wr_count(wr_count_v), .err_count(err_count_v),
    .err_addr(err_addr_v), .bad_idx(bad_idx_v)
  );

  weight_loader #(.N(8), .NUM_WEIGHTS(5), .READ_LAT(RL), .VERIFY(0)) u_dut_nv (
    .clk(clk), .axi_rst(axi_rst), .in_valid(valid_nv), .in_ready(in_ready_nv),
    .in_s(in_s_nv), .in_d(in_d_nv), .in_weight(in_w_nv), .wready(wready_nv),
    .wr_addr(wr_addr_nv), .wdata(wdata_nv), .rd_addr(rd_addr_nv), .rdata(32'd0),
    .busy(busy_nv), .wr_count(wr_count_nv), .err_count(err_count_nv),
    .err_addr(err_addr_nv), .bad_idx(bad_idx_nv)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_wr, exp_err;
  logic [31:0] exp_err_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_addr(input int unsigned s, input int unsigned d);
    return (32'(MASK) * 32'h0100_0000) + 32'(d * 8192) + 32'(s * 4);
  endfunction

  function automatic int unsigned sat16(input int unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic wait_idle_v();
    int t = 0;
    while (in_ready_v !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready_v !== 1'b1) check_eq("idle_timeout", 32'(in_ready_v), 32'd1);
  endtask

  // Offers one entry to the verifying instance and checks timing and state against the model.
  task automatic run_entry(input int unsigned s, input int unsigned d, input int unsigned w,
                           input bit mis, input logic [31:0] mval);
    int wr_hits, bad_hits, busy_cyc, first_wr;
    bit addr_ok, diag, err;
    logic [31:0] ea;
    logic [31:0] wv;
    wv   = 32'(w);
    diag = (s == d);
    ea   = ref_addr(s, d);
    err  = !diag && mis && (mval[WW-1:0] != wv[WW-1:0]);
    wait_idle_v();
    @(negedge clk);
    in_s_v = IW'(s); in_d_v = IW'(d); in_w_v = WW'(w);
    mis_en = mis; mis_val = mval; valid_v = 1'b1;
    @(posedge clk);
    #1 valid_v = 1'b0;
    wr_hits = 0; bad_hits = 0; busy_cyc = 0; first_wr = -1; addr_ok = 1'b1;
    for (int k = 0; k < int'(RL) + 3; k++) begin
      @(negedge clk);
      if (wready_v) begin
        wr_hits++;
        if (first_wr < 0) first_wr = k;
      end
      if (bad_idx_v) bad_hits++;
      if (busy_v) begin
        busy_cyc++;
        if (rd_addr_v !== ea || wr_addr_v !== ea) addr_ok = 1'b0;
      end
    end
    if (!diag) exp_wr = sat16(exp_wr + 1);
    if (err) begin
      exp_err      = sat16(exp_err + 1);
      exp_err_addr = ea;
    end
    check_eq("wready_pulses", 32'(wr_hits), diag ? 32'd0 : 32'd1);
    if (!diag) begin
      check_eq("wready_cycle", 32'(first_wr), 32'd0);
      check_eq("wdata", wdata_v, wv);
    end
    check_eq("bad_idx_pulses", 32'(bad_hits), diag ? 32'd1 : 32'd0);
    check_eq("busy_cycles", 32'(busy_cyc), diag ? 32'd0 : 32'(RL + 2));
    check_eq("addr_stable", 32'(addr_ok), 32'd1);
    check_eq("wr_count", 32'(wr_count_v), 32'(exp_wr));
    check_eq("err_count", 32'(err_count_v), 32'(exp_err));
    check_eq("err_addr", err_addr_v, exp_err_addr);
    check_eq("in_ready_after", 32'(in_ready_v), 32'd1);
  endtask

  initial begin
    int unsigned rs, rd, rw;
    int idx;
    bit acc;
    int wr_cyc[$];
    logic [31:0] wr_ad[$];
    int unsigned es[3] = '{1, 4, 6};
    int unsigned ed[3] = '{2, 0, 3};
    int unsigned ew[3] = '{1, 3, 4};

    axi_rst = 1'b1;
    valid_v = 1'b0; in_s_v = '0; in_d_v = '0; in_w_v = '0; mis_en = 1'b0; mis_val = '0;
    valid_nv = 1'b0; in_s_nv = '0; in_d_nv = '0; in_w_nv = '0;
    exp_wr = 0; exp_err = 0; exp_err_addr = '0;
    repeat (3) @(negedge clk);
    axi_rst = 1'b0;
    check_eq("rst_wready", 32'(wready_v), 32'd0);
    check_eq("rst_wr_count", 32'(wr_count_v), 32'd0);
    check_eq("rst_err_count", 32'(err_count_v), 32'd0);
    check_eq("rst_wr_addr", wr_addr_v, 32'd0);
    check_eq("rst_wdata", wdata_v, 32'd0);
    @(negedge clk);
    check_eq("post_rst_wready", 32'(wready_v), 32'd0);
    check_eq("post_rst_in_ready", 32'(in_ready_v), 32'd1);
    check_eq("post_rst_busy", 32'(busy_v), 32'd0);

    run_entry(3, 5, 4, 1'b0, 32'd0);
    check_eq("basic_addr", wr_addr_v, {MASK, 24'h00A00C});
    check_eq("basic_wr_count", 32'(wr_count_v), 32'd1);
    check_eq("basic_err_count", 32'(err_count_v), 32'd0);

    run_entry(1, 6, 2, 1'b1, 32'd3);
    check_eq("mis_err_count", 32'(err_count_v), 32'd1);
    check_eq("mis_err_addr", err_addr_v, {MASK, 24'h00C004});

    run_entry(4, 4, 1, 1'b0, 32'd0);
    check_eq("diag_wr_count", 32'(wr_count_v), 32'd2);

    for (int i = 0; i < 40; i++) begin
      rs = $urandom_range(0, 7);
      rd = ($urandom_range(0, 5) == 0) ? rs : $urandom_range(0, 7);
      rw = $urandom_range(0, 4);
      run_entry(rs, rd, rw, ($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset while the entry sits in RD_WAIT with a forced mismatch pending.
    wait_idle_v();
    @(negedge clk);
    in_s_v = 3'd2; in_d_v = 3'd7; in_w_v = 3'd1; mis_en = 1'b1; mis_val = 32'd0;
    valid_v = 1'b1;
    @(posedge clk);
    #1 valid_v = 1'b0;
    @(negedge clk);
    check_eq("mid_wready", 32'(wready_v), 32'd1);
    @(negedge clk);
    check_eq("mid_busy", 32'(busy_v), 32'd1);
    axi_rst = 1'b1;
    @(negedge clk);
    axi_rst = 1'b0;
    exp_wr = 0; exp_err = 0; exp_err_addr = '0;
    check_eq("mid_rst_busy", 32'(busy_v), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready_v), 32'd1);
    check_eq("mid_rst_wr_count", 32'(wr_count_v), 32'd0);
    check_eq("mid_rst_wr_addr", wr_addr_v, 32'd0);
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wready_v || err_count_v != 16'd0) idx++;
    end
    check_eq("mid_rst_no_update", 32'(idx), 32'd0);
    check_eq("mid_rst_err_count", 32'(err_count_v), 32'd0);
    mis_en = 1'b0;

    // Saturation: preload the write counter while idle, then issue three writes.
    wait_idle_v();
    @(negedge clk);
    force u_dut_v.wr_count_q = 16'hFFFE;
    @(negedge clk);
    release u_dut_v.wr_count_q;
    exp_wr = 32'hFFFE;
    check_eq("sat_preload", 32'(wr_count_v), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) run_entry(i, i + 3, i + 1, 1'b0, 32'd0);
    check_eq("sat_wr_count", 32'(wr_count_v), 32'h0000FFFF);

    // Back-to-back entries with in_valid held high on the non-verifying instance.
    idx = 0;
    @(negedge clk);
    in_s_nv = IW'(es[0]); in_d_nv = IW'(ed[0]); in_w_nv = WW'(ew[0]); valid_nv = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (wready_nv) begin
        wr_cyc.push_back(c);
        wr_ad.push_back(wr_addr_nv);
      end
      acc = valid_nv && in_ready_nv;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_s_nv = IW'(es[idx]); in_d_nv = IW'(ed[idx]); in_w_nv = WW'(ew[idx]);
        end else begin
          valid_nv = 1'b0;
        end
      end
      @(negedge clk);
    end
    check_eq("b2b_pulses", 32'(wr_cyc.size()), 32'd3);
    for (int i = 0; i < wr_cyc.size(); i++) begin
      check_eq("b2b_addr", wr_ad[i], ref_addr(es[i], ed[i]));
      if (i > 0) check_eq("b2b_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
    end
    check_eq("b2b_wr_count", 32'(wr_count_nv), 32'd3);
    check_eq("b2b_wdata", wdata_nv, 32'(ew[2]));
    check_eq("b2b_idle", 32'(in_ready_nv), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter N, default 8: oscillator count; index width IDX_W = $clog2(N).
REQ-002 SHALL have parameter NUM_WEIGHTS, default 5: weight levels; weight width WEIGHT_W = $clog2(NUM_WEIGHTS).
REQ-003 SHALL have parameter READ_LAT, default 2: cycles from rd_addr stable to rdata valid; legal range is 1..15.
REQ-004 SHALL have parameter VERIFY, default 1: 1 enables readback check after each write.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with the following ports.
- clk  input  1  clock; all state changes on the rising edge.
- axi_rst  input  1  synchronous reset, active-high.
- in_valid  input  1  entry offered.
- in_ready  output  1  entry accepted when in_valid and in_ready are both high.
- in_s  input  IDX_W  source oscillator index.
- in_d  input  IDX_W  destination oscillator index.
- in_weight  input  WEIGHT_W  coupling weight code.
- wready  output  1  write strobe to the coupled-cell matrix.
- wr_addr  output  32  write address.
- wdata  output  32  write data.
- rd_addr  output  32  readback address.
- rdata  input  32  readback data from the matrix.
- busy  output  1  high whenever the state is not IDLE.
- wr_count  output  16  writes issued; saturates at 0xFFFF.
- err_count  output  16  readback mismatches; saturates at 0xFFFF.
- err_addr  output  32  address of the most recent mismatch.
- bad_idx  output  1  one-cycle pulse when a diagonal entry is rejected.

Function
REQ-006 SHALL form the address as {`WEIGHT_ADDR_MASK, zero-extended d (11b) in [23:13], zero-extended s (11b) in [12:2], 2'b00}.
REQ-007 SHALL form wdata as the weight zero-extended to 32 bits.
REQ-008 SHALL implement FSM states IDLE, WRITE, RD_WAIT and CHECK.
REQ-009 SHALL drive in_ready = 1 only in IDLE.
REQ-010 SHALL, on accept with in_s == in_d, latch nothing, pulse bad_idx high the next cycle, and stay in IDLE.
REQ-011 SHALL, on accept with in_s != in_d, latch the address and weight and go to WRITE next cycle.
REQ-012 SHALL hold wready high for exactly one cycle, in WRITE only.
REQ-013 SHALL increment wr_count in WRITE.
REQ-014 SHALL, in WRITE, go to RD_WAIT if VERIFY = 1, else to IDLE.
REQ-015 SHALL stay in RD_WAIT for exactly READ_LAT cycles, counted by a down-counter, then go to CHECK.
REQ-016 SHALL, in CHECK, compare rdata[WEIGHT_W-1:0] with the latched weight.
REQ-017 SHALL, on mismatch in CHECK, increment err_count and load err_addr with the latched address.
REQ-018 SHALL go from CHECK to IDLE unconditionally.
REQ-019 SHALL keep wr_addr, rd_addr and wdata registered and constant from WRITE through CHECK; the matrix muxes the address on wready, so rd_addr must be stable while wready is low.
REQ-020 SHALL give this timing for an entry accepted at edge T:
- wready high in cycle T+1.
- rdata sampled in cycle T+2+READ_LAT.
- next accept possible at T+3+READ_LAT with VERIFY = 1, or at T+2 with VERIFY = 0.
REQ-021 SHALL hold each counter at 0xFFFF once it saturates, without wrapping.
REQ-022 SHALL not drive wready high outside WRITE, including the cycle after reset.

Reset
REQ-023 SHALL, when axi_rst is sampled high, clear in any state:
- state returns to IDLE.
- wready, bad_idx, wr_count, err_count, err_addr, wr_addr, rd_addr and wdata all go to 0.
- in_ready goes to 1 from the first cycle after axi_rst is released.
REQ-024 SHALL, on reset mid-operation (WRITE, RD_WAIT or CHECK), abandon the entry with no count update and no wready pulse.

Structure
REQ-025 SHALL take `WEIGHT_ADDR_MASK from defines.vh and keep address field positions as defines there, shared with the matrix decode.
REQ-026 SHALL be a single module with no sub-module; the FSM, the latency counter and the saturating counters are inline.

Verification
REQ-027 SHALL cover a basic write with N=8, VERIFY=1, READ_LAT=2:
- Stimulus: s=3, d=5, weight=4, with rdata looping back wdata.
- Response: wr_addr = {MASK,24'h00A00C} with wready high for 1 cycle; wdata = 4; wr_count = 1; err_count = 0.
REQ-028 SHALL cover a forced mismatch:
- Stimulus: s=1, d=6, weight=2, with rdata forced to 3.
- Response: err_count = 1; err_addr = {MASK,24'h00C004}.
REQ-029 SHALL cover a diagonal entry:
- Stimulus: s=d=4.
- Response: bad_idx pulses for 1 cycle; no wready; wr_count unchanged.
REQ-030 SHALL cover back-to-back entries with VERIFY=0:
- Stimulus: 3 entries with in_valid held high.
- Response: wready pulses 2 cycles apart; wr_count = 3.
REQ-031 SHALL cover reset mid-operation:
- Stimulus: axi_rst asserted in RD_WAIT.
- Response: next cycle is IDLE; counters are 0; no CHECK update occurs.
REQ-032 SHALL cover saturation:
- Stimulus: preload wr_count = 0xFFFE, then issue 3 writes.
- Response: wr_count = 0xFFFF.
